// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: data-cache miss handler; bursts one block from memory and writes it to the array.
// Optional DCACHE_REFILL_CRITICAL_FIRST_EN: request the missed double word first and fill slots in wrapping order.
module dcache_refill_unit #(
    parameter int double_word_offset_width = 3,
    parameter int line_width = 6,
    localparam int block_size = 1 << double_word_offset_width,
    localparam int tag_width = 32 - double_word_offset_width - 3 - line_width
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        miss_valid,
    output logic                        miss_ready,
    input  logic [31:0]                 miss_address,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_address,
    input  logic                        mem_resp_valid,
    output logic                        mem_resp_ready,
    input  logic [63:0]                 mem_resp_data,
    output logic                        write_in,
    output logic [line_width-1:0]       write_line_index,
    output logic [64*block_size-1:0]    write_block,
    output logic [tag_width-1:0]        write_tag,
    output logic [block_size-1:0]       write_mask,
    output logic                        refill_done,
    output logic                        busy
);
    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DONE} state_t;
    localparam int lo = double_word_offset_width + 3;
    localparam logic [double_word_offset_width:0] cnt_one = 1;
    localparam logic [double_word_offset_width:0] cnt_last = block_size - 1;
    state_t r_state, w_next;
    logic [double_word_offset_width:0] r_cnt;
    logic [31:0] r_addr;
    logic [64*block_size-1:0] r_buf;
    logic [double_word_offset_width-1:0] w_start, w_slot;
    logic w_beat;
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    assign mem_req_address = r_addr & ~32'd7;
    assign w_start = r_addr[lo-1:3];
`else
    assign mem_req_address = r_addr & ~((32'd1 << lo) - 32'd1);
    assign w_start = '0;
`endif
    // Slot index wraps modulo block_size by truncation.
    assign w_slot = w_start + r_cnt[double_word_offset_width-1:0];
    assign w_beat = (r_state == FILL) && mem_resp_valid;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_addr <= '0;
            r_buf <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && miss_valid) r_addr <= miss_address;
            if (r_state == REQ) r_cnt <= '0;
            if (w_beat) begin
                r_buf[{w_slot, 6'b0} +: 64] <= mem_resp_data;
                r_cnt <= r_cnt + cnt_one;
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = miss_valid ? REQ : IDLE;
            REQ:     w_next = mem_req_ready ? FILL : REQ;
            FILL:    w_next = (w_beat && r_cnt == cnt_last) ? WRITE : FILL;
            WRITE:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    assign miss_ready = r_state == IDLE;
    assign mem_req_valid = r_state == REQ;
    assign mem_resp_ready = r_state == FILL;
    assign write_in = r_state == WRITE;
    assign write_mask = {block_size{write_in}};
    assign write_line_index = r_addr[lo+line_width-1:lo];
    assign write_tag = r_addr[31:lo+line_width];
    assign write_block = r_buf;
    assign refill_done = r_state == DONE;
    assign busy = r_state != IDLE;
endmodule

// File: tb/tb_dcache_refill_unit.sv
// tb_dcache_refill_unit: directed refill scenarios; a negedge monitor checks array writes against a queue of expectations.
module tb_dcache_refill_unit;
    localparam int BS = 8;
    typedef struct {
        logic [5:0]   line;
        logic [19:0]  tag;
        logic [511:0] blk;
        int           cyc;
    } exp_t;

    logic clock = 0;
    logic reset = 1;
    logic miss_valid = 0;
    logic miss_ready;
    logic [31:0] miss_address = '0;
    logic mem_req_valid;
    logic mem_req_ready = 0;
    logic [31:0] mem_req_address;
    logic mem_resp_valid = 0;
    logic mem_resp_ready;
    logic [63:0] mem_resp_data = '0;
    logic write_in;
    logic [5:0] write_line_index;
    logic [511:0] write_block;
    logic [19:0] write_tag;
    logic [7:0] write_mask;
    logic refill_done;
    logic busy;

    exp_t exp_q[$];
    exp_t m_e;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_w = -100;
    int t0, waits;

    dcache_refill_unit dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_address(miss_address),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
        .write_in(write_in), .write_line_index(write_line_index), .write_block(write_block),
        .write_tag(write_tag), .write_mask(write_mask), .refill_done(refill_done), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] blk_of(input logic [63:0] base);
        blk_of = '0;
        for (int j = 0; j < BS; j++) blk_of[64*j +: 64] = base + 64'(j);
    endfunction

    function automatic int start_of(input logic [31:0] a);
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        return int'(a[5:3]);
`else
        return 0;
`endif
    endfunction

    task automatic start_miss(input logic [31:0] a, output int t, output int w);
        miss_valid = 1;
        miss_address = a;
        w = 0;
        while (!miss_ready && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        chk("miss_accept", miss_ready, 1);
        t = cyc;
        @(posedge clock); #1;
        miss_valid = 0;
    endtask

    // Memory model: beat k carries the double word belonging to slot (start+k) mod 8, valued base+slot.
    task automatic serve(input logic [31:0] a, input logic [63:0] base, input logic [31:0] req,
                         input int rdly, input int gap_at, input int gap_len, input int nbeats);
        int s;
        s = start_of(a);
        for (int i = 0; i <= rdly; i++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_address", mem_req_address, req);
            mem_req_ready = (i == rdly);
            @(posedge clock); #1;
        end
        mem_req_ready = 0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == gap_at) repeat (gap_len) begin
                mem_resp_valid = 0;
                mem_resp_data = {$urandom, $urandom};
                @(posedge clock); #1;
            end
            chk("resp_ready", mem_resp_ready, 1);
            mem_resp_valid = 1;
            mem_resp_data = base + 64'((s + k) % BS);
            @(posedge clock); #1;
        end
        mem_resp_valid = 0;
    endtask

    task automatic refill(input logic [31:0] a, input logic [63:0] base, input logic [31:0] req_off,
                          input logic [31:0] req_on, input logic [5:0] line, input logic [19:0] tag,
                          input int rdly, input int gap_at, input int gap_len, output int w);
        int t;
        exp_t e;
        logic [31:0] req;
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        req = req_on;
`else
        req = req_off;
`endif
        start_miss(a, t, w);
        e.line = line;
        e.tag = tag;
        e.blk = blk_of(base);
        e.cyc = t + 10 + rdly + gap_len;
        exp_q.push_back(e);
        serve(a, base, req, rdly, gap_at, gap_len, BS);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (write_in) begin
                if (exp_q.size() == 0) chk("unexpected_write", write_in, 0);
                else begin
                    m_e = exp_q.pop_front();
                    chk("write_cycle", cyc, m_e.cyc);
                    chk("write_line", write_line_index, m_e.line);
                    chk("write_tag", write_tag, m_e.tag);
                    chk("write_block", write_block, m_e.blk);
                    chk("write_mask", write_mask, 8'hFF);
                    chk("write_no_done", refill_done, 0);
                    last_w = cyc;
                end
            end
            if (refill_done) begin
                chk("done_cycle", cyc, last_w + 1);
                chk("done_miss_ready", miss_ready, 0);
                chk("done_busy", busy, 1);
                chk("done_mask", write_mask, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) begin
            mem_req_ready = 1'($urandom);
            mem_resp_valid = 1'($urandom);
            mem_resp_data = {$urandom, $urandom};
            @(posedge clock); #1;
            chk("rst_miss_ready", miss_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_write_in", write_in, 0);
            chk("rst_done", refill_done, 0);
            chk("rst_req_valid", mem_req_valid, 0);
            chk("rst_resp_ready", mem_resp_ready, 0);
            chk("rst_req_addr", mem_req_address, 0);
            chk("rst_line_tag_mask", {write_line_index, write_tag, write_mask}, 0);
        end
        mem_req_ready = 0;
        mem_resp_valid = 0;
        reset = 0;
        repeat (2) begin
            @(posedge clock); #1;
            chk("idle_busy", busy, 0);
            chk("idle_miss_ready", miss_ready, 1);
        end
        // basic refill, zero-wait memory
        refill(32'h0000_1234, 64'hA0, 32'h0000_1200, 32'h0000_1230, 6'h08, 20'h00001, 0, 99, 0, waits);
        repeat (3) @(posedge clock);
        #1;
        // stalled request and a two-cycle beat gap
        refill(32'h0000_1234, 64'hA0, 32'h0000_1200, 32'h0000_1230, 6'h08, 20'h00001, 3, 4, 2, waits);
        repeat (3) @(posedge clock);
        #1;
        // back-to-back: second miss held through WRITE and DONE
        refill(32'h0000_2468, 64'hB0, 32'h0000_2440, 32'h0000_2468, 6'h11, 20'h00002, 0, 99, 0, waits);
        refill(32'h0000_3000, 64'hC0, 32'h0000_3000, 32'h0000_3000, 6'h00, 20'h00003, 0, 99, 0, waits);
        chk("b2b_wait_cycles", waits, 2);
        repeat (3) @(posedge clock);
        #1;
        // reset after five beats of FILL
        start_miss(32'h0000_5000, t0, waits);
        serve(32'h0000_5000, 64'hE0, 32'h0000_5000, 0, 99, 0, 5);
        #2 reset = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_miss_ready", miss_ready, 1);
        chk("midrst_write_in", write_in, 0);
        chk("midrst_resp_ready", mem_resp_ready, 0);
        @(posedge clock); #1;
        reset = 0;
        refill(32'h0000_0040, 64'hD0, 32'h0000_0040, 32'h0000_0040, 6'h01, 20'h00000, 0, 99, 0, waits);
        repeat (5) @(posedge clock);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Data-cache miss handler, directly upstream of the dCache register array.
- Accepts one miss address from the cache controller and fetches the full block from memory as double-word beats.
- Assembles the beats into a block buffer, then drives the array's write port (write_in, write_line_index, write_block, write_tag, write_mask) for exactly one cycle.
- Signals completion back to the controller with a one-cycle pulse.

Parameters:
- double_word_offset_width, 3, log2 of double words per block (block_size = 1 << double_word_offset_width).
- line_width, 6, log2 of cache lines; tag_width = 32 - double_word_offset_width - 3 - line_width (20 at defaults).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- miss_valid  in  1  miss request valid.
- miss_ready  out  1  unit can accept a miss.
- miss_address  in  32  byte address that missed.
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_address  out  32  start address of the burst.
- mem_resp_valid  in  1  response beat valid.
- mem_resp_ready  out  1  unit accepts a beat.
- mem_resp_data  in  64  one double word.
- write_in  out  1  array write strobe.
- write_line_index  out  line_width  array line index.
- write_block  out  64*block_size  assembled block; slot j at bits [64*j +: 64].
- write_tag  out  tag_width  tag for the line.
- write_mask  out  block_size  slot enables.
- refill_done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, beat counter=0, captured address=0, block buffer=0.
  - Reset values: miss_ready=1, mem_req_valid=0, mem_resp_ready=0, write_in=0, write_mask=0, refill_done=0, busy=0.
  - mem_req_address, write_line_index and write_tag are 0.
- States: IDLE, REQ, FILL, WRITE, DONE.
- IDLE:
  - miss_ready=1.
  - miss_valid&&miss_ready captures miss_address; next state is REQ.
- REQ:
  - mem_req_valid=1; mem_req_address is held stable until the handshake.
  - Address is block-aligned: captured address with bits [double_word_offset_width+2:0] cleared.
  - mem_req_valid&&mem_req_ready moves to FILL with beat counter=0.
  - mem_req_valid never deasserts before ready.
- FILL:
  - mem_resp_ready=1.
  - Each mem_resp_valid&&mem_resp_ready beat stores mem_resp_data into buffer slot (start_slot + count) mod block_size, then increments count.
  - start_slot=0 unless the optional feature is enabled.
  - On the block_size-th beat, next state is WRITE. Beats with valid low are stall cycles with no state change.
- Beats outside FILL are not accepted (mem_resp_ready=0) and leave the buffer unchanged.
- WRITE:
  - write_in=1 for exactly one cycle with write_mask all ones.
  - write_line_index = addr[line_width+double_word_offset_width+2 : double_word_offset_width+3].
  - write_tag = addr[31 : line_width+double_word_offset_width+3].
  - write_block = buffer. Next state is DONE.
- DONE: refill_done=1 for one cycle, then IDLE. No new miss is accepted in DONE.
- write_in=0 and write_mask=0 in every state except WRITE.
- Minimum latency, zero-wait memory (miss accepted at cycle 0):
  - REQ handshake at cycle 1.
  - Beats in cycles 2..block_size+1.
  - write_in at cycle block_size+2; refill_done at cycle block_size+3.
  - At defaults: cycles 10 and 11.
- One outstanding miss only. The beat counter wraps modulo block_size when computing slot indices; the counter itself is double_word_offset_width+1 bits wide.
- Reset mid-refill: the partial block is discarded, no write_in is issued, and the unit returns to IDLE asynchronously.

Optional Feature:
- Macro: DCACHE_REFILL_CRITICAL_FIRST_EN.
- Defined (critical-word-first):
  - mem_req_address is the captured address double-word aligned (bits [2:0] cleared).
  - start_slot = addr[double_word_offset_width+2:3].
  - Memory returns beats in wrapping order starting at that slot.
- Not defined: block-aligned request address, start_slot=0, beats fill slots in order 0..block_size-1.

Test Plan:
- Reset then idle: reset high with random memory inputs -> miss_ready=1, busy=0, write_in=0, refill_done=0 throughout.
- Basic refill, macro off, zero-wait memory:
  - Stimulus: miss_address=0x0000_1234; beats 0xA0..0xA7.
  - mem_req_address=0x0000_1200.
  - write_in at cycle 10 with line index 0x08, tag 0x00001, mask 0xFF, slot j=0xA0+j.
  - refill_done at cycle 11.
- Stalled memory: mem_req_ready delayed 3 cycles, valid gap after beat 4 -> mem_req_valid and address held, buffer identical to the basic refill case, write_in delayed by 3+gap cycles.
- Back-to-back: second miss_valid held during DONE -> not accepted until IDLE; accepted the following cycle, second refill correct.
- Reset mid-FILL after 5 beats -> no write_in, busy=0 immediately; next miss 0x0000_0040 refills line 0x01 correctly.
- Macro on, miss_address=0x0000_1234:
  - mem_req_address=0x0000_1230; first beat lands in slot 6, then 7, 0..5.
  - Final write_block matches memory order per slot.
